// File: rtl/transpose_buffer_if.sv
// ---------------------------------------------------------------------------
// transpose_buffer_if
//
// Handshake bundle for transpose_buffer.
//   Row side    : in_valid / in_ready / in_data    (COLS-bit row words)
//   Column side : out_valid / out_ready / out_data (ROWS-bit column words)
//                 out_last marks the final column of a matrix.
//
// Modports
//   master : the producer/consumer environment around the buffer
//   slave  : the transpose_buffer itself
// ---------------------------------------------------------------------------
interface transpose_buffer_if #(
  parameter int ROWS = 32,
  parameter int COLS = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [COLS-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [ROWS-1:0] out_data;
  logic            out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/transpose_buffer.sv
// ---------------------------------------------------------------------------
// transpose_buffer
//
// Sequential bit-matrix transpose. Captures a ROWS x COLS bit matrix one row
// word per accepted cycle (FILL), then streams the transpose out one column
// word per accepted cycle (DRAIN). Fill and drain never overlap, so one
// matrix costs at least ROWS + COLS cycles.
//
// Parameters
//   ROWS : rows per matrix, also the output word width   (>= 2)
//   COLS : input row width, also the columns per matrix  (>= 2)
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   reset    : synchronous, active-high; abandons any matrix in progress
//   in_flush : (only with TRANSPOSE_FLUSH_EN) drain a partially filled matrix
//   bus      : transpose_buffer_if.slave
//                in_valid/in_ready/in_data    row handshake
//                out_valid/out_ready/out_data column handshake
//                out_last                     final column of the matrix
//   busy     : a matrix is partially filled or draining
//
// Optional feature
//   TRANSPOSE_FLUSH_EN : adds in_flush. A flush in FILL with at least one row
//   written (or being written this cycle) starts DRAIN early; rows that were
//   never written read as 0 in out_data.
//
// Storage is deliberately not reset. Rows beyond the valid row count are
// masked on the read side, so stale contents never reach out_data.
// ---------------------------------------------------------------------------
module transpose_buffer #(
  parameter int ROWS = 32,
  parameter int COLS = 64
) (
  input  logic                clk,
  input  logic                reset,
`ifdef TRANSPOSE_FLUSH_EN
  input  logic                in_flush,
`endif
  transpose_buffer_if.slave   bus,
  output logic                busy
);

  localparam int RCW = $clog2(ROWS) + 1;
  localparam int CCW = $clog2(COLS) + 1;
  localparam int CIW = $clog2(COLS);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state;
  logic [RCW-1:0]  row_cnt;
  logic [CCW-1:0]  col_cnt;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            out_last_r;

  logic [COLS-1:0] mem [ROWS];

  logic            row_hs;
  logic            col_hs;
  logic            last_row;
  logic            last_col;
  logic            flush_go;
  logic [ROWS-1:0] col_word;

  // Handshake qualifiers. in_ready/out_valid mirror the state register,
  // so a row can only land in FILL and a column only leaves in DRAIN.
  assign row_hs   = bus.in_valid  & in_ready_r;
  assign col_hs   = bus.out_ready & out_valid_r;
  assign last_row = (row_cnt == RCW'(ROWS - 1));
  assign last_col = (col_cnt == CCW'(COLS - 1));

`ifdef TRANSPOSE_FLUSH_EN
  // A flush needs something to drain: either rows already written or a
  // row landing on this very edge, which is then included in the matrix.
  assign flush_go = in_flush & in_ready_r & ((row_cnt != '0) | row_hs);
`else
  assign flush_go = 1'b0;
`endif

  // Control FSM: state, counters and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      row_cnt     <= '0;
      col_cnt     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          out_last_r <= 1'b0;
          if (row_hs) begin
            row_cnt <= row_cnt + RCW'(1);
          end
          // row_cnt keeps the number of rows written; it becomes the
          // read mask for the whole drain.
          if ((row_hs && last_row) || flush_go) begin
            state       <= DRAIN;
            col_cnt     <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        DRAIN: begin
          if (col_hs) begin
            if (last_col) begin
              state       <= FILL;
              row_cnt     <= '0;
              col_cnt     <= '0;
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
            end else begin
              col_cnt    <= col_cnt + CCW'(1);
              // Flag the column that will be presented next cycle.
              out_last_r <= (col_cnt == CCW'(COLS - 2));
            end
          end
        end
        default: begin
          state       <= FILL;
          row_cnt     <= '0;
          col_cnt     <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  // Row storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (row_hs) begin
      mem[row_cnt[RCW-2:0]] <= bus.in_data;
    end
  end

  // Column read: bit r of the column word is element [r][col_cnt], forced
  // to 0 for rows that were not written in this matrix.
  always_comb begin
    col_word = '0;
    if (out_valid_r) begin
      for (int r = 0; r < ROWS; r++) begin
        if (RCW'(r) < row_cnt) begin
          col_word[r] = mem[r][col_cnt[CIW-1:0]];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = col_word;
  assign bus.out_last  = out_last_r;
  assign busy          = (row_cnt != '0) | (state == DRAIN);

endmodule

// File: tb/tb_transpose_buffer.sv
module tb_transpose_buffer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  transpose_buffer_if #(.ROWS(4),  .COLS(8))  b4 ();
  transpose_buffer_if #(.ROWS(32), .COLS(64)) b32 ();
  logic busy4;
  logic busy32;
`ifdef TRANSPOSE_FLUSH_EN
  logic flush4 = 1'b0;
  logic flush32 = 1'b0;
`endif

  transpose_buffer #(.ROWS(4), .COLS(8)) dut4 (
    .clk      (clk),
    .reset    (reset),
`ifdef TRANSPOSE_FLUSH_EN
    .in_flush (flush4),
`endif
    .bus      (b4),
    .busy     (busy4)
  );

  transpose_buffer #(.ROWS(32), .COLS(64)) dut32 (
    .clk      (clk),
    .reset    (reset),
`ifdef TRANSPOSE_FLUSH_EN
    .in_flush (flush32),
`endif
    .bus      (b32),
    .busy     (busy32)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       vin;
    logic [7:0] din;
    logic       ordy;
    logic       irdy;
    logic       ovld;
    logic [3:0] od;
    logic       olast;
    logic       bsy;
  } vec_t;

  vec_t tbl [13];
  logic [3:0]  exp_rst   [8];
  logic [3:0]  exp_stall [8];
  logic [63:0] rows32 [2][32];
  logic [31:0] exp32  [2][64];
  int hs;
  int col;

  initial begin
    // Basic 4x8 transpose, out_ready held high.
    tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h4, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};

    // Rows F0,0F,33,CC transposed.
    exp_rst   = '{4'h6, 4'h6, 4'hA, 4'hA, 4'h5, 4'h5, 4'h9, 4'h9};
    // Rows 81,42,24,18 transposed.
    exp_stall = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h8, 4'h4, 4'h2, 4'h1};

    for (int i = 0; i < 32; i++) begin
      rows32[0][i] = 64'(i);
      rows32[1][i] = {32'(i) ^ 32'h5A5A5A5A, ~32'(i)};
    end
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 64; c++)
        for (int r = 0; r < 32; r++)
          exp32[m][c][r] = rows32[m][r][c];

    b4.in_valid = 1'b0;  b4.in_data = '0;  b4.out_ready = 1'b0;
    b32.in_valid = 1'b0; b32.in_data = '0; b32.out_ready = 1'b0;

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready",  b4.in_ready,  1'b1);
    check("rst_out_valid", b4.out_valid, 1'b0);
    check("rst_out_last",  b4.out_last,  1'b0);
    check("rst_busy",      busy4,        1'b0);
    check("rst32_in_ready",  b32.in_ready,  1'b1);
    check("rst32_out_valid", b32.out_valid, 1'b0);

    // Table-driven basic transpose.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      b4.in_valid  = tbl[i].vin;
      b4.in_data   = tbl[i].din;
      b4.out_ready = tbl[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i),  b4.in_ready,  tbl[i].irdy);
      check($sformatf("v%0d_out_valid", i), b4.out_valid, tbl[i].ovld);
      check($sformatf("v%0d_out_last", i),  b4.out_last,  tbl[i].olast);
      check($sformatf("v%0d_busy", i),      busy4,        tbl[i].bsy);
      if (tbl[i].ovld)
        check($sformatf("v%0d_out_data", i), b4.out_data, tbl[i].od);
    end

    // Reset after two rows, then four fresh rows.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b4.in_valid = 1'b1; b4.in_data = 8'hFF; b4.out_ready = 1'b0;
    end
    @(negedge clk);
    b4.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_busy_before", busy4, 1'b1);
    check("midrst_out_valid_during", b4.out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_out_valid_after", b4.out_valid, 1'b0);
    check("midrst_in_ready_after",  b4.in_ready,  1'b1);
    check("midrst_busy_after",      busy4,        1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b4.in_valid = 1'b1;
      case (i)
        0: b4.in_data = 8'hF0;
        1: b4.in_data = 8'h0F;
        2: b4.in_data = 8'h33;
        default: b4.in_data = 8'hCC;
      endcase
      #1;
      check("midrst_fill_in_ready", b4.in_ready, 1'b1);
      check("midrst_fill_out_valid", b4.out_valid, 1'b0);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      b4.in_valid = 1'b0; b4.out_ready = 1'b1;
      #1;
      check($sformatf("midrst_c%0d_valid", c), b4.out_valid, 1'b1);
      check($sformatf("midrst_c%0d_data", c),  b4.out_data,  exp_rst[c]);
      check($sformatf("midrst_c%0d_last", c),  b4.out_last,  (c == 7));
    end
    @(negedge clk);
    b4.out_ready = 1'b0;
    #1;
    check("midrst_done_in_ready", b4.in_ready, 1'b1);
    check("midrst_done_out_valid", b4.out_valid, 1'b0);

    // Stalled drain with out_ready toggling and in_valid held high.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b4.in_valid = 1'b1;
      case (i)
        0: b4.in_data = 8'h81;
        1: b4.in_data = 8'h42;
        2: b4.in_data = 8'h24;
        default: b4.in_data = 8'h18;
      endcase
    end
    hs = 0;
    col = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      b4.in_valid  = 1'b1;
      b4.in_data   = 8'hAA;
      b4.out_ready = (k % 2 == 0);
      #1;
      check($sformatf("stall_k%0d_in_ready", k),  b4.in_ready,  1'b0);
      check($sformatf("stall_k%0d_out_valid", k), b4.out_valid, 1'b1);
      check($sformatf("stall_k%0d_data", k),      b4.out_data,  exp_stall[col]);
      check($sformatf("stall_k%0d_last", k),      b4.out_last,  (col == 7));
      if (b4.out_valid && b4.out_ready) begin
        hs++;
        col = (col < 7) ? col + 1 : col;
      end
    end
    @(negedge clk);
    b4.in_valid = 1'b0; b4.out_ready = 1'b0;
    #1;
    check("stall_handshakes", hs, 8);
    check("stall_done_in_ready", b4.in_ready, 1'b1);
    check("stall_done_out_valid", b4.out_valid, 1'b0);

    // Default geometry: two back-to-back 32x64 matrices.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        b32.in_valid = 1'b1; b32.in_data = rows32[m][i]; b32.out_ready = 1'b1;
        #1;
        check($sformatf("m%0d_r%0d_in_ready", m, i), b32.in_ready, 1'b1);
      end
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        if (m == 0) begin
          b32.in_valid = 1'b1; b32.in_data = rows32[1][0];
        end else begin
          b32.in_valid = 1'b0;
        end
        #1;
        check($sformatf("m%0d_c%0d_valid", m, c), b32.out_valid, 1'b1);
        check($sformatf("m%0d_c%0d_data", m, c),  b32.out_data,  exp32[m][c]);
        check($sformatf("m%0d_c%0d_last", m, c),  b32.out_last,  (c == 63));
        if (m == 0 && c == 0)
          check("m0_c0_const", b32.out_data, 32'hAAAAAAAA);
      end
    end
    @(negedge clk);
    b32.in_valid = 1'b0; b32.out_ready = 1'b0;
    #1;
    check("m32_done_in_ready", b32.in_ready, 1'b1);
    check("m32_done_out_valid", b32.out_valid, 1'b0);
    check("m32_done_busy", busy32, 1'b0);

`ifdef TRANSPOSE_FLUSH_EN
    // Partial matrix: two rows, then flush. Rows 2,3 hold stale data.
    @(negedge clk);
    b4.in_valid = 1'b1; b4.in_data = 8'hFF;
    @(negedge clk);
    b4.in_data = 8'h0F;
    @(negedge clk);
    b4.in_valid = 1'b0; flush4 = 1'b1;
    #1;
    check("flush_pre_out_valid", b4.out_valid, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      flush4 = 1'b0; b4.out_ready = 1'b1;
      #1;
      check($sformatf("flush_c%0d_valid", c), b4.out_valid, 1'b1);
      check($sformatf("flush_c%0d_data", c),  b4.out_data,  (c < 4) ? 4'h3 : 4'h1);
      check($sformatf("flush_c%0d_last", c),  b4.out_last,  (c == 7));
    end
    @(negedge clk);
    b4.out_ready = 1'b0;
    #1;
    check("flush_done_in_ready", b4.in_ready, 1'b1);
    // Flush with no rows written is ignored.
    @(negedge clk);
    flush4 = 1'b1;
    @(negedge clk);
    flush4 = 1'b0;
    #1;
    check("flush_empty_out_valid", b4.out_valid, 1'b0);
    check("flush_empty_in_ready",  b4.in_ready,  1'b1);
    check("flush_empty_busy",      busy4,        1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
